// File: rtl/stopwatch_pkg.sv
// Shared stopwatch codes: command bus values and mode encodings.
// Used by the button command generator and the counter block.
package stopwatch_pkg;

  localparam int CMD_W  = 3;
  localparam int MODE_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_HOLD  = 3'b000,
    CMD_RUN   = 3'b001,
    CMD_PAUSE = 3'b010,
    CMD_CLEAR = 3'b011
  } cmd_e;

  typedef enum logic [MODE_W-1:0] {
    M_IDLE  = 2'b00,
    M_RUN   = 2'b01,
    M_PAUSE = 2'b10
  } mode_e;

  // Mode reached by a short press; unknown encodings fall back to idle.
  function automatic mode_e short_next(input mode_e m);
    case (m)
      M_IDLE:  short_next = M_RUN;
      M_RUN:   short_next = M_PAUSE;
      M_PAUSE: short_next = M_RUN;
      default: short_next = M_IDLE;
    endcase
  endfunction

  // Command issued by a short press; recovery from a bad mode is silent.
  function automatic cmd_e short_cmd(input mode_e m);
    case (m)
      M_IDLE:  short_cmd = CMD_RUN;
      M_RUN:   short_cmd = CMD_PAUSE;
      M_PAUSE: short_cmd = CMD_RUN;
      default: short_cmd = CMD_HOLD;
    endcase
  endfunction

endpackage

// File: rtl/stopwatch_cmd_gen_debounce.sv
// Button synchronizer and debouncer.
// Emits the debounced level plus one-cycle rise/fall pulses.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  // Two-flop sync, then accept a level after it stays put long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_rise  <= ~r_level;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/stopwatch_cmd_gen.sv
// Push-button front end producing stopwatch mode commands.
// Optional STOPWATCH_CMD_DROP_CNT_EN adds a dropped-press counter.
module stopwatch_cmd_gen
  import stopwatch_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [CMD_W-1:0]  cmd,
  output logic [MODE_W-1:0] mode,
  output logic              led_run
`ifdef STOPWATCH_CMD_DROP_CNT_EN
  ,
  output logic [7:0]        dropped_cnt
`endif
);

  localparam int TW = $clog2(LONG_CYCLES + 1);
  localparam logic [TW-1:0] LONG_MAX = TW'(LONG_CYCLES);
  localparam logic [TW-1:0] LONG_PRE = TW'(LONG_CYCLES - 1);

  logic          w_level;
  logic          w_rise;
  logic          w_fall;
  logic          w_xfer;
  logic          w_pending;

  logic [TW-1:0] r_timer;
  logic          r_short_evt;
  logic          r_long_evt;
  logic          r_valid;
  cmd_e          r_cmd;
  mode_e         r_mode;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (btn),
    .o_level(w_level),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  assign w_xfer    = r_valid & cmd_ready;
  assign w_pending = r_valid & ~cmd_ready;

  // Press timer; long fires once at saturation, short only on release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_timer     <= '0;
      r_short_evt <= 1'b0;
      r_long_evt  <= 1'b0;
    end else begin
      r_short_evt <= w_fall & (r_timer != LONG_MAX);
      r_long_evt  <= w_level & ~w_rise & (r_timer == LONG_PRE);
      if (w_rise) begin
        r_timer <= '0;
      end else if (w_level && r_timer != LONG_MAX) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  // Mode FSM with a one-deep command slot on a valid/ready handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_cmd   <= CMD_HOLD;
      r_mode  <= M_IDLE;
    end else if (r_long_evt) begin
      r_valid <= 1'b1;
      r_cmd   <= CMD_CLEAR;
      r_mode  <= M_IDLE;
    end else if (r_short_evt && !w_pending) begin
      r_valid <= (short_cmd(r_mode) != CMD_HOLD);
      r_cmd   <= short_cmd(r_mode);
      r_mode  <= short_next(r_mode);
    end else begin
      if (w_xfer) begin
        r_valid <= 1'b0;
        r_cmd   <= CMD_HOLD;
      end
      if (!(r_mode inside {M_IDLE, M_RUN, M_PAUSE})) begin
        r_mode <= M_IDLE;
      end
    end
  end

  assign cmd_valid = r_valid;
  assign cmd       = r_cmd;
  assign mode      = r_mode;
  assign led_run   = (r_mode == M_RUN);

`ifdef STOPWATCH_CMD_DROP_CNT_EN
  logic       w_drop;
  logic [7:0] r_drop_cnt;

  assign w_drop = r_short_evt & w_pending & ~r_long_evt;

  // Count short presses lost to a pending command, saturating.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_cnt <= 8'd0;
    end else if (w_drop && r_drop_cnt != 8'hFF) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign dropped_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_stopwatch_cmd_gen.sv
// Directed bench for stopwatch_cmd_gen with a command scoreboard.
// Small DEBOUNCE/LONG settings keep presses short.
module tb_stopwatch_cmd_gen;
  import stopwatch_pkg::*;

  localparam int DB = 4;
  localparam int LG = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [1:0] mode;
  logic       led_run;
`ifdef STOPWATCH_CMD_DROP_CNT_EN
  logic [7:0] dropped_cnt;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_pop = -1;
  int t_start;

  typedef struct packed {
    logic [2:0] c;
    logic [1:0] m;
  } exp_t;

  exp_t q[$];
  exp_t e;

  stopwatch_cmd_gen #(
    .DEBOUNCE_CYCLES(DB),
    .LONG_CYCLES    (LG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid),
    .cmd      (cmd),
    .mode     (mode),
    .led_run  (led_run)
`ifdef STOPWATCH_CMD_DROP_CNT_EN
    ,
    .dropped_cnt(dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hi, input int lo);
    btn = 1'b1;
    cycles(hi);
    btn = 1'b0;
    cycles(lo);
  endtask

  // Scoreboard: every transfer pops one expected command.
  always @(negedge clk) begin
    if (!rst) begin
      if (!cmd_valid) chk("hold_when_idle", 8'(cmd), 8'h00);
      if (cmd_valid && cmd_ready) begin
        chk("xfer_expected", 8'(q.size() == 0), 8'h00);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("xfer_cmd", 8'(cmd), 8'(e.c));
          chk("xfer_mode", 8'(mode), 8'(e.m));
          chk("xfer_led", 8'(led_run), 8'(e.m == M_RUN));
          last_pop = cyc;
        end
      end
    end
  end

  initial begin
    // 1: button held through reset
    rst = 1'b1;
    btn = 1'b1;
    cmd_ready = 1'b1;
    cycles(3);
    chk("rst_valid", 8'(cmd_valid), 8'h0);
    chk("rst_cmd", 8'(cmd), 8'h0);
    chk("rst_mode", 8'(mode), 8'h0);
    chk("rst_led", 8'(led_run), 8'h0);
    q.push_back('{c: CMD_RUN, m: M_RUN});
    rst = 1'b0;
    cycles(15);
    btn = 1'b0;
    cycles(15);
    chk("s1_sb", 8'(q.size()), 8'd0);
    chk("s1_mode", 8'(mode), 8'(M_RUN));

    // 4: long press from run
    q.push_back('{c: CMD_CLEAR, m: M_IDLE});
    t_start = cyc;
    press(40, 15);
    chk("s4_sb", 8'(q.size()), 8'd0);
    chk("s4_mode", 8'(mode), 8'(M_IDLE));
    chk("s4_latency",
        8'((last_pop - t_start) >= 26 && (last_pop - t_start) <= 30),
        8'd1);

    // 2: three short presses
    q.push_back('{c: CMD_RUN, m: M_RUN});
    press(10, 10);
    chk("s2_mode1", 8'(mode), 8'(M_RUN));
    chk("s2_led1", 8'(led_run), 8'd1);
    q.push_back('{c: CMD_PAUSE, m: M_PAUSE});
    press(10, 10);
    chk("s2_mode2", 8'(mode), 8'(M_PAUSE));
    chk("s2_led2", 8'(led_run), 8'd0);
    q.push_back('{c: CMD_RUN, m: M_RUN});
    press(10, 10);
    chk("s2_mode3", 8'(mode), 8'(M_RUN));
    chk("s2_led3", 8'(led_run), 8'd1);
    chk("s2_sb", 8'(q.size()), 8'd0);

    // 3: glitches shorter than debounce
    repeat (5) press(3, 3);
    cycles(10);
    chk("s3_mode", 8'(mode), 8'(M_RUN));
    chk("s3_valid", 8'(cmd_valid), 8'd0);

    // 5: pending command, dropped short, long overwrite
    q.push_back('{c: CMD_CLEAR, m: M_IDLE});
    press(40, 15);
    chk("s5_idle", 8'(mode), 8'(M_IDLE));
    cmd_ready = 1'b0;
    press(10, 10);
    chk("s5_pend_valid", 8'(cmd_valid), 8'd1);
    chk("s5_pend_cmd", 8'(cmd), 8'(CMD_RUN));
    chk("s5_pend_mode", 8'(mode), 8'(M_RUN));
    press(10, 10);
    chk("s5_drop_valid", 8'(cmd_valid), 8'd1);
    chk("s5_drop_cmd", 8'(cmd), 8'(CMD_RUN));
    chk("s5_drop_mode", 8'(mode), 8'(M_RUN));
`ifdef STOPWATCH_CMD_DROP_CNT_EN
    chk("s5_drop_cnt", dropped_cnt, 8'd1);
`endif
    press(40, 15);
    chk("s5_ovr_valid", 8'(cmd_valid), 8'd1);
    chk("s5_ovr_cmd", 8'(cmd), 8'(CMD_CLEAR));
    chk("s5_ovr_mode", 8'(mode), 8'(M_IDLE));
    q.push_back('{c: CMD_CLEAR, m: M_IDLE});
    cmd_ready = 1'b1;
    cycles(3);
    chk("s5_done_valid", 8'(cmd_valid), 8'd0);
    chk("s5_done_cmd", 8'(cmd), 8'd0);
    chk("s5_sb", 8'(q.size()), 8'd0);

    // 6: async reset mid-press with a pending command
    cmd_ready = 1'b0;
    press(10, 10);
    chk("s6_pend", 8'(cmd_valid), 8'd1);
    btn = 1'b1;
    cycles(3);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_rst_valid", 8'(cmd_valid), 8'd0);
    chk("s6_rst_cmd", 8'(cmd), 8'd0);
    chk("s6_rst_mode", 8'(mode), 8'd0);
    chk("s6_rst_led", 8'(led_run), 8'd0);
    btn = 1'b0;
    cycles(3);
    rst = 1'b0;
    cmd_ready = 1'b1;
    cycles(20);
    chk("s6_quiet", 8'(cmd_valid), 8'd0);
    chk("s6_sb_quiet", 8'(q.size()), 8'd0);
    q.push_back('{c: CMD_RUN, m: M_RUN});
    press(10, 10);
    chk("s6_sb", 8'(q.size()), 8'd0);
    chk("s6_mode", 8'(mode), 8'(M_RUN));
`ifdef STOPWATCH_CMD_DROP_CNT_EN
    chk("s6_drop_cnt", dropped_cnt, 8'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stopwatch_cmd_gen.md
Name: stopwatch_cmd_gen

Overview:
Single push-button front end that produces mode commands for the stopwatch counter/display block. It synchronizes and debounces the raw button, then classifies each press as short or long. A mode FSM turns each press into a 3-bit command, which is offered on a valid/ready handshake. The 3-bit command encoding is identical to the stopwatch's mode input encoding.

Parameters:
DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a new button level (10 ms at 50 MHz)
LONG_CYCLES, 50000000, debounced-high clk cycles that classify a press as long (1 s at 50 MHz)

Ports:
clk  input  1  system clock
rst  input  1  reset
btn  input  1  raw push-button, asynchronous, active-high
cmd_ready  input  1  consumer accepts cmd this cycle
cmd_valid  output  1  cmd holds a pending command
cmd  output  3  command code; CMD_HOLD whenever cmd_valid=0
mode  output  2  current commanded mode
led_run  output  1  high while mode==M_RUN

Interface decision: reset rst, asynchronous, active-high; clock clk.

Behaviour:
- Command codes: CMD_HOLD=3'b000, CMD_RUN=3'b001, CMD_PAUSE=3'b010, CMD_CLEAR=3'b011. Codes 100..111 are never driven.
- Mode encodings: M_IDLE=2'b00, M_RUN=2'b01, M_PAUSE=2'b10. Encoding 11 is unreachable and recovers to M_IDLE.
- Reset values: cmd_valid=0, cmd=000, mode=M_IDLE, led_run=0. The synchronizer flops, the debounced level and all counters are also 0. Reset is asynchronous and takes effect immediately, including in the middle of a press or handshake.
- Synchronizer: 2 flops on btn.
- Debounce counter:
  - Counts while the synced value differs from the debounced level.
  - Clears on any cycle where they match.
  - On the edge where the count reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A button already held at reset release therefore registers as a press once it has been stable for DEBOUNCE_CYCLES.
- Press timer:
  - Clears on the debounced rising edge.
  - Increments while the debounced level is high and saturates at LONG_CYCLES.
  - Width is $clog2(LONG_CYCLES+1).
- Long event: fires once, on the edge where the timer reaches LONG_CYCLES. The later release generates no event.
- Short event: fires on the debounced falling edge if no long event fired during that press.
- Mode FSM on an event:
  - Short press: M_IDLE→M_RUN (CMD_RUN), M_RUN→M_PAUSE (CMD_PAUSE), M_PAUSE→M_RUN (CMD_RUN).
  - Long press: any mode→M_IDLE (CMD_CLEAR).
- Latency: mode and cmd update, and cmd_valid rises, on the clock edge one cycle after the event is detected.
- Handshake:
  - cmd and cmd_valid stay stable while cmd_valid=1 and cmd_ready=0.
  - A transfer occurs on any edge with cmd_valid=1 and cmd_ready=1. cmd_valid drops on that edge and cmd returns to 000.
  - Back-to-back commands need a new event; there is no queueing beyond one.
- Event while a command is pending:
  - A short event is dropped, and mode does not change.
  - A long event overwrites the pending cmd with CMD_CLEAR and sets mode=M_IDLE; cmd_valid stays 1.
- Event on the same edge as a transfer: the transfer completes and the new event is loaded. cmd_valid stays 1 with the new cmd, following the normal (not-pending) rules.
- led_run is combinational from mode.

Optional Feature:
Macro STOPWATCH_CMD_DROP_CNT_EN.
- Defined: adds output port dropped_cnt [7:0], reset value 0. It increments by 1 on each short event dropped due to a pending command, saturates at 255, and is cleared only by rst.
- Undefined: the port and its counter do not exist, and the rest of the behaviour is identical.

Decomposition:
- Package stopwatch_pkg holds the CMD_* codes, the M_* encodings, and their width constants (CMD_W=3, MODE_W=2). The stopwatch counter block shares this package.
- Sub-module btn_debounce contains the synchronizer and debounce counter. It takes DEBOUNCE_CYCLES as a parameter and outputs the debounced level plus 1-cycle rise and fall pulses.
- The press timer, FSM and handshake stay in the top module.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
1. Reset asserted with btn=1, then released → cmd_valid=0, cmd=000, mode=00, led_run=0 during reset. A single CMD_RUN appears after debounce, followed by release.
2. cmd_ready=1; three short presses (btn high 10 cycles, low 10 cycles) → exactly three single-cycle valid pulses with cmd 001, 010, 001; mode goes 01, 10, 01; led_run=1, 0, 1.
3. btn glitches of 3 cycles high, repeated 5 times → no debounced change, cmd_valid stays 0, mode unchanged.
4. In M_RUN, btn held 40 cycles → cmd=011 valid exactly once, 1 cycle after the timer reaches 20; mode=00; release produces no command.
5. cmd_ready=0, short press gives pending 001. A second short press → cmd stays 001 and mode stays 01 (dropped_cnt=1 if the macro is enabled). A following long press → cmd becomes 011 and mode 00. Raising cmd_ready → one transfer, then cmd_valid=0.
6. rst pulsed while cmd_valid=1 and btn is mid-press → outputs go to reset values asynchronously; no command is issued until a fresh debounced press.
